cipher_cfg_loader: RTL
======================

// Module: cipher_cfg_loader
// PURPOSE
//  Upstream config stage for the XOR cipher core. Accepts a 32-bit LFSR taps word and a
//  32-bit LFSR state word over a valid/ready handshake. Serialises them LSB-first onto the
//  core's cfg_en/cfg_i scan chain, holding cfg_en high for exactly TAPS_W+STATE_W cycles.
//  Optionally captures the previous chain contents returned on cfg_o.
// PARAMETERS
//  TAPS_W   32  width of taps word (upper part of chain)
//  STATE_W  32  width of LFSR state word (lower part of chain)
//  CHAIN_W = TAPS_W+STATE_W (localparam, 64); counter width $clog2(CHAIN_W)+1
// PORTS
//  clk             in   1        rising-edge clock, shared with cipher core
//  rst_n           in   1        asynchronous, active-low reset
//  load_valid      in   1        load request; payload stable while high
//  load_ready      out  1        high in IDLE only; transfer = load_valid & load_ready
//  load_taps       in   TAPS_W   taps word, sampled on transfer
//  load_state      in   STATE_W  LFSR state word, sampled on transfer
//  abort           in   1        cancel an in-progress shift
//  cfg_en          out  1        registered; scan-enable to core
//  cfg_i           out  1        registered; scan-data to core
//  cfg_o           in   1        scan-out from core (chain bit 0)
//  busy            out  1        high in SHIFT
//  done            out  1        1-cycle pulse: full word shifted in
//  aborted         out  1        1-cycle pulse: shift cancelled
//  readback        out  CHAIN_W  previous chain contents (CFG_READBACK_EN only)
//  readback_valid  out  1        1-cycle pulse, coincident with done
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; cfg_en, cfg_i, busy, done, aborted,
//    readback_valid=0; readback=0; shift reg/counter=0; load_ready=1 once rst_n=1.
//  - FSM states: IDLE, SHIFT.
//  - IDLE: load_ready=1. On transfer, shreg<={load_taps,load_state}, cnt<=0, ->SHIFT.
//  - SHIFT: cfg_en=1, cfg_i=shreg[0]; each cycle shreg>>=1, cnt++.
//    Chain shifts in at MSB, out at bit 0, so LSB-first delivery leaves chain == payload.
//  - Latency: cfg_en rises the cycle after transfer and stays high exactly CHAIN_W cycles.
//  - After last shift (cnt==CHAIN_W-1): ->IDLE; cfg_en low next cycle.
//    done pulses in that first IDLE cycle, with load_ready=1.
//  - Back-to-back loads: a transfer in the done cycle gives exactly 1 cycle of cfg_en=0
//    between chains. The core LFSR advances once in that gap (accepted; system-visible).
//  - abort in SHIFT (cnt<CHAIN_W-1): ->IDLE, cfg_en=0 next cycle, aborted pulses, no done.
//    Chain is left partially loaded.
//  - abort on the last shift cycle is ignored: shift completes, done pulses.
//  - abort in IDLE: no effect.
//  - load_valid while busy: ignored (load_ready=0); payload not sampled.
//  - Simultaneous transfer and abort in IDLE: transfer taken, abort ignored.
//  - Reset mid-SHIFT: outputs clear immediately, no done/aborted. Core must be reset with
//    it (shared reset tree) so its defaults are restored.
// CONFIGURATION
//  CFG_READBACK_EN defined:
//   - each SHIFT cycle: rbreg<={cfg_o,rbreg[CHAIN_W-1:1]}
//   - on done: readback<=rbreg (old chain, incl. live LFSR state), readback_valid pulses
//   - readback holds until next done or reset; abort does not update it.
//  CFG_READBACK_EN undefined:
//   - no capture register; readback tied 0, readback_valid tied 0, cfg_o unused.
// TESTING
//  1 Reset: rst_n low mid-run -> all outputs 0 async. Release -> load_ready=1, cfg_en=0.
//  2 Load taps=0x80200003, state=0x00000001 -> cfg_en high 64 cycles.
//    cfg_i = bits 0..63 of 0x8020000300000001. Core chain equals that word.
//    done at cycle 65 after transfer.
//  3 Hold load_valid high, two payloads -> second accepted in done cycle.
//    Exactly one cfg_en=0 cycle between the 64-cycle bursts.
//  4 abort at shift cycle 10 -> cfg_en=0 from cycle 11, aborted=1 one cycle, done never.
//    abort on cycle 63 -> done pulses, aborted=0.
//  5 load_valid pulsed during SHIFT with different payload -> ignored.
//    Chain equals first payload.
//  6 CFG_READBACK_EN, load immediately after reset (core defaults, LFSR held by cfg_en)
//    -> readback=0x0000006000000055 with readback_valid=done. Without macro -> readback=0.

Source files
------------

// File: rtl/cipher_cfg_loader.sv
// Serialises a {taps,state} payload LSB-first onto the cipher core's cfg_en/cfg_i scan chain.
// Optional macro CFG_READBACK_EN captures the previous chain contents from cfg_o.
module cipher_cfg_loader #(
   parameter int TAPS_W  = 32,
   parameter int STATE_W = 32,
   localparam int CHAIN_W = TAPS_W + STATE_W,
   localparam int CNT_W   = $clog2(CHAIN_W) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_valid,
   output logic               load_ready,
   input  logic [TAPS_W-1:0]  load_taps,
   input  logic [STATE_W-1:0] load_state,
   input  logic               abort,
   output logic               cfg_en,
   output logic               cfg_i,
   input  logic               cfg_o,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [CHAIN_W-1:0] readback,
   output logic               readback_valid
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state_q, state_d;
   logic [CHAIN_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               cfg_en_q, cfg_en_d;
   logic               cfg_i_q, cfg_i_d;
   logic               done_q, done_d;
   logic               aborted_q, aborted_d;
   logic               last_shift;

   assign last_shift = (cnt_q == CNT_W'(CHAIN_W - 1));

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      cfg_en_d  = 1'b0;
      cfg_i_d   = 1'b0;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_valid) begin
               shreg_d  = {load_taps, load_state};
               cnt_d    = '0;
               state_d  = SHIFT;
               cfg_en_d = 1'b1;
               cfg_i_d  = load_state[0];
            end
         end
         SHIFT: begin
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            // the final bit always lands, so abort loses to completion here
            if (last_shift) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (abort) begin
               state_d   = IDLE;
               aborted_d = 1'b1;
            end else begin
               cfg_en_d = 1'b1;
               cfg_i_d  = shreg_q[1];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         cnt_q     <= '0;
         cfg_en_q  <= 1'b0;
         cfg_i_q   <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         cfg_en_q  <= cfg_en_d;
         cfg_i_q   <= cfg_i_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   assign load_ready = rst_n & (state_q == IDLE);
   assign busy       = (state_q == SHIFT);
   assign cfg_en     = cfg_en_q;
   assign cfg_i      = cfg_i_q;
   assign done       = done_q;
   assign aborted    = aborted_q;

`ifdef CFG_READBACK_EN
   logic [CHAIN_W-1:0] rbreg_q, rbreg_d;
   logic [CHAIN_W-1:0] readback_q, readback_d;
   logic               rbv_q, rbv_d;

   // old chain bits fall out of cfg_o in the same order the new ones go in
   always_comb begin
      rbreg_d    = rbreg_q;
      readback_d = readback_q;
      rbv_d      = 1'b0;
      if (state_q == SHIFT) begin
         rbreg_d = {cfg_o, rbreg_q[CHAIN_W-1:1]};
         if (last_shift) begin
            readback_d = rbreg_d;
            rbv_d      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rbreg_q    <= '0;
         readback_q <= '0;
         rbv_q      <= 1'b0;
      end else begin
         rbreg_q    <= rbreg_d;
         readback_q <= readback_d;
         rbv_q      <= rbv_d;
      end
   end

   assign readback       = readback_q;
   assign readback_valid = rbv_q;
`else
   logic unused_cfg_o;
   assign unused_cfg_o   = cfg_o;
   assign readback       = '0;
   assign readback_valid = 1'b0;
`endif

endmodule
